pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the pipelined CPU datapath: PC, IF/ID and ID/EX registers, register file.
- Holds a scoreboard of destination registers in flight in EX and MEM.
- Generates PC-write, IF/ID-write, IF/ID-flush and ID/EX-bubble controls for load-use/RAW stalls and taken-branch squash.
- Sequences start and halt/drain of the core.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encodings,
// the hardwired-zero register index, drain depth and control-bundle constants.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int unsigned X0_REG      = 0;
  localparam logic [1:0]  DRAIN_DEPTH = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  // Stall and halt both freeze fetch and inject a bubble, exactly like IDLE.
  localparam ctrl_t CTRL_HOLD  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_ISSUE = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Source-operand check against the EX/MEM destination scoreboard; pure combinational.
// Reads of x0 never hit since x0 is hardwired to zero.
module pipe_hazard_ctrl_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wr,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wr,
  output logic                  hit
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = ex_wr  && (rs == ex_rd);
  assign mem_match = mem_wr && (rs == mem_rd);
  assign hit       = rs_used && (rs != REG_ADDR_W'(X0_REG)) && (ex_match || mem_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall / branch squash / start-halt-drain.
// Optional perf counters enabled by PIPE_HAZARD_CTRL_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_halt_i,
  input  logic                  ex_branch_taken_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  halted_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  state_e                state;
  logic [1:0]            drain_cnt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_wr;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_wr;

  logic  rs1_hit;
  logic  rs2_hit;
  logic  hazard;
  logic  take_halt;
  logic  take_issue;
  ctrl_t ctrl;

  pipe_hazard_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs1 (
    .rs      (id_rs1_i),
    .rs_used (id_rs1_used_i),
    .ex_rd   (ex_rd),
    .ex_wr   (ex_wr),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .hit     (rs1_hit)
  );

  pipe_hazard_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs2 (
    .rs      (id_rs2_i),
    .rs_used (id_rs2_used_i),
    .ex_rd   (ex_rd),
    .ex_wr   (ex_wr),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .hit     (rs2_hit)
  );

  assign hazard = id_valid_i && (rs1_hit || rs2_hit);

  // Branch squash outranks hazard, which outranks halt acceptance.
  always_comb begin
    ctrl       = CTRL_HOLD;
    take_halt  = 1'b0;
    take_issue = 1'b0;
    if (state == ST_RUN) begin
      if (ex_branch_taken_i) begin
        ctrl = CTRL_FLUSH;
      end else if (hazard) begin
        ctrl = CTRL_HOLD;
      end else if (id_valid_i && id_halt_i) begin
        ctrl      = CTRL_HOLD;
        take_halt = 1'b1;
      end else begin
        ctrl       = CTRL_ISSUE;
        take_issue = 1'b1;
      end
    end
  end

  assign pc_write_o    = ctrl.pc_write;
  assign ifid_write_o  = ctrl.ifid_write;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_bubble_o = ctrl.idex_bubble;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      drain_cnt <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) state <= ST_RUN;
        end
        ST_RUN: begin
          if (take_halt) begin
            state     <= ST_HALT;
            drain_cnt <= DRAIN_DEPTH;
          end
        end
        ST_HALT: begin
          if (drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only an issued instruction enters EX; every other cycle shifts in a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_rd  <= '0;
      ex_wr  <= 1'b0;
      mem_rd <= '0;
      mem_wr <= 1'b0;
    end else begin
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      if (take_issue && id_valid_i) begin
        ex_rd <= id_rd_i;
        ex_wr <= id_reg_write_i && (id_rd_i != REG_ADDR_W'(X0_REG));
      end else begin
        ex_rd <= '0;
        ex_wr <= 1'b0;
      end
    end
  end

  assign halted_o = (state == ST_HALT) && !ex_wr && !mem_wr && (drain_cnt == 2'd0);

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign stall_evt = (state == ST_RUN) && !ex_branch_taken_i && hazard;
  assign flush_evt = (state == ST_RUN) && ex_branch_taken_i;

  // Saturating: a pegged counter stays at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, async-reset sequence, and
// randomized traffic against an in-flight-destination reference model.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic [4:0]  id_rd_i;
  logic        id_reg_write_i;
  logic        id_halt_i;
  logic        ex_branch_taken_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        halted_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .id_valid_i        (id_valid_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .id_rd_i           (id_rd_i),
    .id_reg_write_i    (id_reg_write_i),
    .id_halt_i         (id_halt_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_bubble_o     (idex_bubble_o),
    .halted_o          (halted_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit pcw, input bit ifw, input bit fl,
                            input bit bub, input bit hlt, input longint st, input longint fc);
    check({tag, ".pc_write"},    pc_write_o,    pcw);
    check({tag, ".ifid_write"},  ifid_write_o,  ifw);
    check({tag, ".ifid_flush"},  ifid_flush_o,  fl);
    check({tag, ".idex_bubble"}, idex_bubble_o, bub);
    check({tag, ".halted"},      halted_o,      hlt);
    check({tag, ".stall_cnt"},   stall_cnt_o,   st * PERF);
    check({tag, ".flush_cnt"},   flush_cnt_o,   fc * PERF);
  endtask

  // Reference model: run state, destinations in flight (-1 = none), drain timer, event counts.
  int     m_state;   // 0 idle, 1 run, 2 halt
  int     m_ex;
  int     m_mem;
  int     m_drain;
  longint m_stall;
  longint m_flush;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  task automatic model_reset();
    m_state = 0; m_ex = -1; m_mem = -1; m_drain = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic bit m_reads(input logic [4:0] rs, input logic used);
    return used && (rs != 0) && ((int'(rs) == m_ex) || (int'(rs) == m_mem));
  endfunction

  // 0 frozen (idle/halt), 1 squash, 2 stall, 3 halt accept, 4 issue
  function automatic int m_action();
    if (m_state != 1) return 0;
    if (ex_branch_taken_i) return 1;
    if (id_valid_i && (m_reads(id_rs1_i, id_rs1_used_i) || m_reads(id_rs2_i, id_rs2_used_i))) return 2;
    if (id_valid_i && id_halt_i) return 3;
    return 4;
  endfunction

  task automatic model_check(input string tag);
    int a;
    a = m_action();
    check_outs(tag, (a == 1 || a == 4), (a == 1 || a == 4), (a == 1), (a != 4),
               (m_state == 2 && m_ex < 0 && m_mem < 0 && m_drain == 0), m_stall, m_flush);
  endtask

  task automatic model_step();
    int a;
    int next_ex;
    int old_state;
    a = m_action();
    old_state = m_state;
    next_ex = -1;
    case (a)
      1: if (m_flush < CNT_MAX) m_flush++;
      2: if (m_stall < CNT_MAX) m_stall++;
      3: begin m_state = 2; m_drain = 2; end
      4: if (id_valid_i && id_reg_write_i && id_rd_i != 0) next_ex = int'(id_rd_i);
      default: ;
    endcase
    if (old_state == 0 && start_i) m_state = 1;
    if (old_state == 2 && m_drain > 0) m_drain--;
    m_mem = m_ex;
    m_ex  = next_ex;
  endtask

  task automatic drive(input bit start, input bit vld, input int rs1, input int rs2,
                       input bit u1, input bit u2, input int rd, input bit rw,
                       input bit halt, input bit br);
    start_i = start; id_valid_i = vld; id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2);
    id_rs1_used_i = u1; id_rs2_used_i = u2; id_rd_i = 5'(rd); id_reg_write_i = rw;
    id_halt_i = halt; ex_branch_taken_i = br;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    check_outs("reset", 0, 0, 0, 1, 0, 0, 0);
    rst_i = 1'b0;
  endtask

  typedef struct {
    bit start, vld;
    int rs1, rs2;
    bit u1, u2;
    int rd;
    bit rw, halt, br;
    bit pcw, ifw, fl, bub, hlt;
    int st, fc;
  } vec_t;

  function automatic vec_t mk(input bit start, input bit vld, input int rs1, input int rs2,
                              input bit u1, input bit u2, input int rd, input bit rw,
                              input bit halt, input bit br, input bit pcw, input bit ifw,
                              input bit fl, input bit bub, input bit hlt, input int st, input int fc);
    vec_t v;
    v.start = start; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.halt = halt; v.br = br;
    v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.bub = bub; v.hlt = hlt; v.st = st; v.fc = fc;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    //            st vl r1 r2 u1 u2 rd rw ht br   pcw ifw fl bub hlt stall flush
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0,  0, 0); // idle ignores branch
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0,  0, 0); // start seen, still idle
    tbl[2]  = mk(0, 1, 1, 2, 1, 1, 5, 1, 0, 0,   1, 1, 0, 0, 0,  0, 0); // add x5 issues
    tbl[3]  = mk(0, 1, 5, 0, 1, 0, 3, 1, 0, 0,   0, 0, 0, 1, 0,  0, 0); // reads x5: EX hit
    tbl[4]  = mk(0, 1, 5, 0, 1, 0, 3, 1, 0, 0,   0, 0, 0, 1, 0,  1, 0); // MEM hit
    tbl[5]  = mk(0, 1, 5, 0, 1, 0, 3, 1, 0, 0,   1, 1, 0, 0, 0,  2, 0); // issues
    tbl[6]  = mk(0, 1, 0, 0, 1, 1, 0, 1, 0, 0,   1, 1, 0, 0, 0,  2, 0); // writes x0
    tbl[7]  = mk(0, 1, 0, 0, 1, 1, 5, 1, 0, 0,   1, 1, 0, 0, 0,  2, 0); // reads x0, writes x5
    tbl[8]  = mk(0, 1, 6, 7, 1, 1, 6, 0, 0, 0,   1, 1, 0, 0, 0,  2, 0); // independent x6/x7
    tbl[9]  = mk(0, 1, 5, 0, 1, 0, 4, 1, 0, 1,   1, 1, 1, 1, 0,  2, 0); // branch over hazard
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   1, 1, 0, 0, 0,  2, 1); // add x7
    tbl[11] = mk(0, 1, 7, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0,  2, 1); // halt accepted
    tbl[12] = mk(1, 1, 7, 7, 1, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0,  2, 1); // halt ignores start/br
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0,  2, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1,  2, 1); // drained
    tbl[15] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1,  2, 1);

    // Directed table
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].start, tbl[i].vld, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
            tbl[i].rd, tbl[i].rw, tbl[i].halt, tbl[i].br);
      #3;
      check_outs($sformatf("vec%0d", i), tbl[i].pcw, tbl[i].ifw, tbl[i].fl, tbl[i].bub,
                 tbl[i].hlt, tbl[i].st, tbl[i].fc);
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset in the middle of a stall
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    @(posedge clk_i); #1;
    drive(0, 1, 5, 5, 0, 1, 2, 1, 0, 0);
    #3;
    check_outs("arst.stall1", 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk_i); #1;
    check_outs("arst.stall2", 0, 0, 0, 1, 0, 1, 0);
    #2;
    rst_i = 1'b1;
    #1;
    check_outs("arst.async", 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0);
      #3;
      model_check($sformatf("rnd%0d", i));
      @(posedge clk_i);
      model_step();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
